mult_share_arbiter: RTL
=======================

Name: mult_share_arbiter

Overview:
- Shares one pipelined 32x32->64 Karatsuba multiplier among NUM_REQ requesters.
- Round-robin arbitration on the issue side.
- Records each issued operation's requester ID in an in-order tag FIFO, then routes each multiplier result back to the requester that issued it.
- Sits between the ElGamal modular-arithmetic engines and the single shared multiplier instance.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
TAG_DEPTH, 8, max operations in flight, counting the issue register plus the tag FIFO (power of 2, >=2)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
req_a_tdata  in  NUM_REQ*32  operand A per requester; requester i at bits [32i+31:32i]
req_b_tdata  in  NUM_REQ*32  operand B per requester, same packing
req_tvalid  in  NUM_REQ  operand pair valid per requester
req_tready  out  NUM_REQ  one-hot grant/accept
rsp_tdata  out  64  result, broadcast to all requesters
rsp_tvalid  out  NUM_REQ  one-hot result valid
rsp_tready  in  NUM_REQ  result accept per requester
m_a_tdata  out  32  multiplier operand A
m_b_tdata  out  32  multiplier operand B
m_a_tvalid  out  1  multiplier A valid
m_b_tvalid  out  1  multiplier B valid
m_a_tready  in  1  multiplier A ready
m_b_tready  in  1  multiplier B ready
m_out_tdata  in  64  multiplier product
m_out_tvalid  in  1  product valid
m_out_tready  out  1  product accept
err_orphan  out  1  sticky: product arrived with no tag outstanding
perf_ops  out  32  completed-result counter (optional feature)
perf_stall  out  32  full-stall cycle counter (optional feature)

Behaviour:
- Reset (rst=0, async): everything clears.
  - Issue register, tag FIFO, round-robin pointer (points at requester 0) and err_orphan all clear.
  - All outputs 0: req_tready, rsp_tvalid, m_*_tvalid, m_out_tready, rsp_tdata, m_*_tdata.
  - Clears mid-operation, dropping any in-flight tags. The multiplier is reset by the same rst.
- Issue register: holds a, b, id and a valid bit.
  - m_a_tvalid = m_b_tvalid = issue valid; m_a_tdata and m_b_tdata come from the register.
  - Multiplier accept = issue valid & m_a_tready & m_b_tready.
  - On accept, push id into the tag FIFO.
- Outstanding count = FIFO count + issue valid.
- Grant condition: (issue empty OR accept this cycle) AND outstanding-after-accept < TAG_DEPTH.
  - When the condition holds, select the first requester with req_tvalid set, searching from rr_ptr upward with wrap.
  - Assert its req_tready (one-hot, combinational), load a, b, id into the issue register, and set rr_ptr = id+1 mod NUM_REQ.
  - If no requester is valid, rr_ptr is unchanged.
- Latency: request handshake at cycle N -> m_*_tvalid high at N+1. Back-to-back issue at 1 op/cycle while the multiplier is ready.
- Return path: while the FIFO is not empty, head = FIFO head id.
  - rsp_tvalid[head] = m_out_tvalid; rsp_tdata = m_out_tdata; m_out_tready = rsp_tready[head].
  - Result handshake pops the FIFO.
  - Backpressure from a slow head requester stalls all results (in-order; no reordering).
- Simultaneous push and pop: FIFO count unchanged. Pointers wrap modulo TAG_DEPTH.
- FIFO empty but m_out_tvalid=1: set err_orphan (sticky until reset), drive m_out_tready=1 to drain, all rsp_tvalid=0.
- Full (outstanding=TAG_DEPTH): no grants; req_tready=0; requesters hold data (stream rules).
- A requester must not drop req_tvalid before its handshake. The arbiter does not require this; a requester that drops is simply skipped.

Optional Feature:
MULT_ARB_PERF_EN
- Defined:
  - perf_ops increments on each result handshake.
  - perf_stall increments each cycle any req_tvalid=1 while outstanding=TAG_DEPTH.
  - Both 32-bit, wrap at 2^32, clear on reset.
- Not defined: perf_ops and perf_stall tied to 0; counters not synthesised.

Test Plan:
1. Single op: req0 a=0x0000FFFF, b=0x00010001 -> m_*_tvalid next cycle; rsp_tvalid[0] with rsp_tdata=0x00000000FFFFFFFF; rsp_tvalid[1] stays 0.
2. Round-robin: both requesters valid continuously, multiplier always ready -> grants alternate 0,1,0,1; results return tagged in the same order with correct products (e.g. 3*5=15 to req0, 7*9=63 to req1).
3. Full: m_out_tready path held by rsp_tready=0, 8 ops issued -> req_tready=0 from the 9th request on. perf_stall counts stall cycles when MULT_ARB_PERF_EN is defined; 0 otherwise.
4. Head backpressure: head=req1 with rsp_tready[1]=0 for 5 cycles -> m_out_tready=0, FIFO count unchanged, no result delivered to req0; release -> in-order drain.
5. Orphan: drive m_out_tvalid=1 with FIFO empty -> err_orphan=1 and stays high, m_out_tready=1, rsp_tvalid=0.
6. Reset mid-operation: rst=0 with 3 ops outstanding -> all outputs 0 immediately (async). After release, rr_ptr=0 and a new req1 op completes correctly.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Shares one pipelined 32x32->64 multiplier among NUM_REQ requesters.
// Issue side: round-robin grant into a single issue register feeding the
// multiplier. Return side: an in-order tag FIFO of requester IDs steers each
// product back to the requester that issued it.
// Optional feature: define MULT_ARB_PERF_EN to build the perf_ops and
// perf_stall counters; otherwise both outputs are tied to zero.

module mult_share_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int TAG_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ*32-1:0]  req_a_tdata,
  input  logic [NUM_REQ*32-1:0]  req_b_tdata,
  input  logic [NUM_REQ-1:0]     req_tvalid,
  output logic [NUM_REQ-1:0]     req_tready,
  output logic [63:0]            rsp_tdata,
  output logic [NUM_REQ-1:0]     rsp_tvalid,
  input  logic [NUM_REQ-1:0]     rsp_tready,
  output logic [31:0]            m_a_tdata,
  output logic [31:0]            m_b_tdata,
  output logic                   m_a_tvalid,
  output logic                   m_b_tvalid,
  input  logic                   m_a_tready,
  input  logic                   m_b_tready,
  input  logic [63:0]            m_out_tdata,
  input  logic                   m_out_tvalid,
  output logic                   m_out_tready,
  output logic                   err_orphan,
  output logic [31:0]            perf_ops,
  output logic [31:0]            perf_stall
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;

  // Issue register
  logic          iss_valid;
  logic [31:0]   iss_a;
  logic [31:0]   iss_b;
  logic [IW-1:0] iss_id;

  // Tag FIFO
  logic [IW-1:0] tag_mem [TAG_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] tag_count;

  logic [IW-1:0] rr_ptr;
  logic          orphan_q;

  logic          accept;
  logic          pop;
  logic          fifo_nonempty;
  logic          grant_ok;
  logic          grant;
  logic          found;
  logic [IW-1:0] sel;
  logic [IW-1:0] rr_next;
  logic [IW-1:0] head;
  logic [CW-1:0] outstanding;

  logic [31:0]   a_arr [NUM_REQ];
  logic [31:0]   b_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a_tdata[32*g +: 32];
    assign b_arr[g] = req_b_tdata[32*g +: 32];
  end

  // The accept moves an op from the issue register into the FIFO, so it does
  // not change the outstanding total; pops are deliberately not credited here
  // to keep the result-ready path out of the grant logic.
  assign accept        = iss_valid & m_a_tready & m_b_tready;
  assign outstanding   = tag_count + CW'(iss_valid);
  assign grant_ok      = (~iss_valid | accept) & (outstanding < CW'(TAG_DEPTH));
  assign grant         = grant_ok & found;
  assign fifo_nonempty = (tag_count != '0);
  assign head          = tag_mem[rd_ptr];
  assign pop           = fifo_nonempty & m_out_tvalid & rsp_tready[head];
  assign rr_next       = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;

  assign m_a_tvalid = iss_valid;
  assign m_b_tvalid = iss_valid;
  assign m_a_tdata  = iss_a;
  assign m_b_tdata  = iss_b;
  assign err_orphan = orphan_q;

  // Round-robin search: first valid requester starting at rr_ptr, with wrap
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_tvalid[IW'(idx)]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  // Combinational one-hot grant and result steering, all forced low in reset
  always_comb begin
    req_tready   = '0;
    rsp_tvalid   = '0;
    rsp_tdata    = '0;
    m_out_tready = 1'b0;
    if (rst) begin
      if (grant) req_tready[sel] = 1'b1;
      if (fifo_nonempty) begin
        rsp_tdata    = m_out_tdata;
        m_out_tready = rsp_tready[head];
        if (m_out_tvalid) rsp_tvalid[head] = 1'b1;
      end else begin
        m_out_tready = m_out_tvalid;
      end
    end
  end

  // Issue register: loaded on grant, emptied when the multiplier takes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_valid <= 1'b0;
      iss_a     <= '0;
      iss_b     <= '0;
      iss_id    <= '0;
    end else if (grant) begin
      iss_valid <= 1'b1;
      iss_a     <= a_arr[sel];
      iss_b     <= b_arr[sel];
      iss_id    <= sel;
    end else if (accept) begin
      iss_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves past the requester just granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr <= '0;
    else if (grant) rr_ptr <= rr_next;
  end

  // Tag storage written on multiplier accept; contents need no reset
  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr] <= iss_id;
  end

  // Tag FIFO pointers and occupancy; pointers wrap naturally at TAG_DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_count <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   tag_count <= tag_count + 1'b1;
        2'b01:   tag_count <= tag_count - 1'b1;
        default: tag_count <= tag_count;
      endcase
    end
  end

  // Sticky flag for a product that shows up with no tag to route it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) orphan_q <= 1'b0;
    else if (!fifo_nonempty && m_out_tvalid) orphan_q <= 1'b1;
  end

`ifdef MULT_ARB_PERF_EN
  logic [31:0] ops_q;
  logic [31:0] stall_q;

  // Completed results and cycles spent full while someone was waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      if (pop) ops_q <= ops_q + 32'd1;
      if ((|req_tvalid) && (outstanding == CW'(TAG_DEPTH))) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_ops   = ops_q;
  assign perf_stall = stall_q;
`else
  assign perf_ops   = '0;
  assign perf_stall = '0;
`endif

endmodule
